// File: rtl/addsub_serial.sv
// Nibble-serial saturating add/subtract: one 4-bit adder slice reused over
// NIBBLES cycles behind a start/done handshake, with 16-bit or per-nibble saturation.
module addsub_serial #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 padd,
  input  logic                 sub,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [4*NIBBLES-1:0] s,
  output logic                 ovfl,
  output logic                 cout
);
  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state, state_nxt;
  logic [W-1:0]         a_r, b_r, res;
  logic                 padd_r, sub_r, carry;
  logic [IDX_W-1:0]     idx;
  logic [NIBBLES-1:0]   ovf_nib;
  logic [3:0]           a_nib, b_nib;
  logic                 cin, ovf_cur;
  logic [4:0]           sum;
  logic [3:0]           low;

  // Overflow direction follows operand a's sign: overflow implies both signs agree.
  function automatic logic [W-1:0] saturate(input logic [W-1:0]       raw,
                                            input logic [W-1:0]       op_a,
                                            input logic [NIBBLES-1:0] ovf,
                                            input logic               pmode);
    logic [W-1:0] r;
    r = raw;
    if (pmode) begin
      for (int k = 0; k < NIBBLES; k++)
        if (ovf[k]) r[4*k +: 4] = op_a[4*k+3] ? 4'h8 : 4'h7;
    end else if (ovf[NIBBLES-1]) begin
      r = op_a[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
    end
    return r;
  endfunction

  assign a_nib   = a_r[4*int'(idx) +: 4];
  assign b_nib   = b_r[4*int'(idx) +: 4];
  assign cin     = padd_r ? sub_r : carry;
  assign sum     = {1'b0, a_nib} + {1'b0, b_nib} + {4'b0, cin};
  assign low     = {1'b0, a_nib[2:0]} + {1'b0, b_nib[2:0]} + {3'b0, cin};
  assign ovf_cur = low[3] ^ sum[4];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == IDX_W'(NIBBLES - 1)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state != IDLE);
  end

  // Operand latch, nibble slice and result commit
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx     <= '0;
      carry   <= 1'b0;
      ovf_nib <= '0;
      done    <= 1'b0;
      s       <= '0;
      ovfl    <= 1'b0;
      cout    <= 1'b0;
    end else begin
      done <= (state == DONE);
      case (state)
        IDLE: if (start) begin
          a_r    <= a;
          b_r    <= b ^ {W{sub}};
          padd_r <= padd;
          sub_r  <= sub;
          idx    <= '0;
          carry  <= sub;
        end
        RUN: begin
          res     <= {sum[3:0], res[W-1:4]};
          ovf_nib <= {ovf_cur, ovf_nib[NIBBLES-1:1]};
          carry   <= sum[4];
          idx     <= idx + 1'b1;
        end
        DONE: begin
          s    <= saturate(res, a_r, ovf_nib, padd_r);
          ovfl <= padd_r ? |ovf_nib : ovf_nib[NIBBLES-1];
          cout <= carry;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_addsub_serial.sv
// Self-checking bench for addsub_serial: directed cases, handshake, reset
// and randomized operations against an integer-arithmetic reference model.
module tb_addsub_serial;
  logic        clk = 1'b0;
  logic        rst_n, start, padd, sub;
  logic [15:0] a, b, s;
  logic        busy, done, ovfl, cout;
  int          vectors = 0;
  int          errors  = 0;

  addsub_serial #(.NIBBLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .padd(padd), .sub(sub),
    .a(a), .b(b), .busy(busy), .done(done), .s(s), .ovfl(ovfl), .cout(cout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Saturating signed add/sub from plain integer arithmetic.
  function automatic void ref_op(input logic [15:0] ra, input logic [15:0] rb,
                                 input logic rp, input logic rs,
                                 output logic [15:0] es, output logic eo, output logic ec);
    int x, y, r;
    logic signed [3:0] nx, ny;
    logic [3:0] nib;
    es = '0;
    eo = 1'b0;
    if (!rp) begin
      x = $signed(ra);
      y = $signed(rb);
      r = rs ? x - y : x + y;
      if (r > 32767)       begin es = 16'h7FFF; eo = 1'b1; end
      else if (r < -32768) begin es = 16'h8000; eo = 1'b1; end
      else                 es = r[15:0];
      ec = rs ? (int'(ra) >= int'(rb)) : (int'(ra) + int'(rb) > 65535);
    end else begin
      for (int k = 0; k < 4; k++) begin
        nx = ra[4*k +: 4];
        ny = rb[4*k +: 4];
        x = nx;
        y = ny;
        r = rs ? x - y : x + y;
        if (r > 7)       begin nib = 4'h7; eo = 1'b1; end
        else if (r < -8) begin nib = 4'h8; eo = 1'b1; end
        else             nib = r[3:0];
        es[4*k +: 4] = nib;
      end
      ec = rs ? (int'(ra[15:12]) >= int'(rb[15:12]))
              : (int'(ra[15:12]) + int'(rb[15:12]) > 15);
    end
  endfunction

  // Issue one op with a single-cycle start; report start-to-done latency and busy cycles.
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic tp,
                       input logic ts, output int lat, output int busy_cnt);
    a = ta; b = tb; padd = tp; sub = ts; start = 1'b1;
    tick();
    start = 1'b0;
    a = $urandom; b = $urandom; padd = $urandom; sub = $urandom;
    lat = -1;
    busy_cnt = busy ? 1 : 0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (busy) busy_cnt++;
      if (done) begin lat = k; break; end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; padd = 1'b0; sub = 1'b0; a = '0; b = '0;
    tick(); tick();
    vectors++;
    if ({busy, done, s, ovfl, cout} !== 20'h0) begin
      errors++;
      $display("FAIL reset: busy=%b done=%b s=%h ovfl=%b cout=%b, want all zero",
               busy, done, s, ovfl, cout);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    logic [15:0] ta[6] = '{16'h1234, 16'h0005, 16'h7FFF, 16'h8000, 16'h7171, 16'h1234};
    logic [15:0] tb[6] = '{16'h0101, 16'h0007, 16'h0001, 16'h0001, 16'h1717, 16'h1111};
    logic        tp[6] = '{0, 0, 0, 0, 1, 1};
    logic        ts[6] = '{0, 1, 0, 1, 0, 0};
    logic [15:0] xs[6] = '{16'h1335, 16'hFFFE, 16'h7FFF, 16'h8000, 16'h7777, 16'h2345};
    logic        xo[6] = '{0, 0, 1, 1, 1, 0};
    logic        xc[6] = '{0, 0, 0, 1, 0, 0};
    int lat, bc;
    for (int i = 0; i < 6; i++) begin
      do_op(ta[i], tb[i], tp[i], ts[i], lat, bc);
      vectors++;
      if (lat !== 5 || bc !== 5) begin
        errors++;
        $display("FAIL dir%0d timing: latency=%0d busy_cycles=%0d, want 5/5", i, lat, bc);
      end
      vectors++;
      if (s !== xs[i] || ovfl !== xo[i] || cout !== xc[i]) begin
        errors++;
        $display("FAIL dir%0d result: s=%h ovfl=%b cout=%b, want s=%h ovfl=%b cout=%b",
                 i, s, ovfl, cout, xs[i], xo[i], xc[i]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [15:0] ra, rb, es;
    logic rp, rs, eo, ec;
    int lat, bc;
    logic [15:0] edges[4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    for (int i = 0; i < 150; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      rp = 1'($urandom);
      rs = 1'($urandom);
      ref_op(ra, rb, rp, rs, es, eo, ec);
      do_op(ra, rb, rp, rs, lat, bc);
      vectors++;
      if (lat !== 5 || s !== es || ovfl !== eo || cout !== ec) begin
        errors++;
        $display("FAIL rand%0d a=%h b=%h padd=%b sub=%b: lat=%0d s=%h ovfl=%b cout=%b, want lat=5 s=%h ovfl=%b cout=%b",
                 i, ra, rb, rp, rs, lat, s, ovfl, cout, es, eo, ec);
      end
      if ($urandom_range(0, 1) == 1) tick();
    end
  endtask

  task automatic test_handshake();
    int dn = 0;
    a = 16'h0102; b = 16'h0304; padd = 1'b0; sub = 1'b0; start = 1'b1;
    tick();                                   // E0
    start = 1'b0; tick();                     // E1, cycle 2 begins
    start = 1'b1; a = 16'h7000; b = 16'h7000; tick();
    start = 1'b0; tick(); tick();             // E3, E4: cycle 5 (DONE) begins
    start = 1'b1; tick();                     // E5
    start = 1'b0;
    if (done) dn++;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (done) dn++;
    end
    vectors++;
    if (dn !== 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL handshake pulses: done_pulses=%0d busy=%b, want 1/0", dn, busy);
    end
    vectors++;
    if (s !== 16'h0406 || ovfl !== 1'b0) begin
      errors++;
      $display("FAIL handshake result: s=%h ovfl=%b, want 0406/0", s, ovfl);
    end
  endtask

  task automatic test_back_to_back();
    int gap = -1;
    logic [15:0] s1;
    a = 16'h4000; b = 16'h4000; padd = 1'b0; sub = 1'b0; start = 1'b1;
    for (int k = 0; k < 20 && !done; k++) tick();
    s1 = s;
    a = 16'h0010; b = 16'h0020; sub = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 1) start = 1'b0;
      if (done) begin gap = k; break; end
    end
    vectors++;
    if (s1 !== 16'h7FFF) begin
      errors++;
      $display("FAIL b2b first: s=%h, want 7fff", s1);
    end
    vectors++;
    if (gap !== 6 || s !== 16'hFFF0 || cout !== 1'b0) begin
      errors++;
      $display("FAIL b2b second: gap=%0d s=%h cout=%b, want 6/fff0/0", gap, s, cout);
    end
    tick();
  endtask

  task automatic test_reset_mid_op();
    int dn = 0, lat, bc;
    a = 16'h1111; b = 16'h2222; padd = 1'b0; sub = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();                           // third RUN cycle
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vectors++;
    if ({busy, done, s, ovfl, cout} !== 20'h0) begin
      errors++;
      $display("FAIL midreset: busy=%b done=%b s=%h ovfl=%b cout=%b, want all zero",
               busy, done, s, ovfl, cout);
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done) dn++;
    end
    vectors++;
    if (dn !== 0) begin
      errors++;
      $display("FAIL midreset stray done: pulses=%0d, want 0", dn);
    end
    do_op(16'h0002, 16'h0003, 1'b0, 1'b0, lat, bc);
    vectors++;
    if (lat !== 5 || s !== 16'h0005) begin
      errors++;
      $display("FAIL midreset fresh op: lat=%0d s=%h, want 5/0005", lat, s);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_reset_mid_op();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
